// File: rtl/dram_rascas_seq_pkg.sv
// Shared state encoding, counter width and timing defaults for the DRAM RAS/CAS sequencer.
// The CBR refresh states exist only when DRAM_CBR_REFRESH_EN is defined.
package dram_rascas_seq_pkg;

  localparam int unsigned CNT_W          = 4;
  localparam int unsigned RAS_TO_MUX_DEF = 1;
  localparam int unsigned MUX_TO_CAS_DEF = 1;
  localparam int unsigned PRECHARGE_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAS     = 3'd1,
    ST_MUX     = 3'd2,
    ST_CAS     = 3'd3,
    ST_RFSH    = 3'd4,
    ST_PRECHG  = 3'd5
`ifdef DRAM_CBR_REFRESH_EN
    ,
    ST_CBR_CAS = 3'd6,
    ST_CBR_RAS = 3'd7
`endif
  } state_e;

  // A state that lasts N cycles loads N-1: the transition fires on the edge that sees zero.
  function automatic logic [CNT_W-1:0] delay_load(input int unsigned cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dram_rascas_seq_delay_cnt.sv
// Loadable down-counter timing the RAS-to-mux, mux-to-CAS and precharge intervals.
// Load wins over counting; the count stops at zero and zero_o flags it.
module dram_delay_cnt
  import dram_rascas_seq_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dram_rascas_seq.sv
// Converts Z80 memory/refresh cycles into registered nRAS/nCAS/nWE and 74157 mux controls.
// DRAM_CBR_REFRESH_EN selects CAS-before-RAS refresh instead of RAS-only; nras falls one edge after the request.
module dram_rascas_seq
  import dram_rascas_seq_pkg::*;
#(
  parameter int unsigned RAS_TO_MUX = RAS_TO_MUX_DEF,
  parameter int unsigned MUX_TO_CAS = MUX_TO_CAS_DEF,
  parameter int unsigned PRECHARGE  = PRECHARGE_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic nmreq,
  input  logic nrfsh,
  input  logic nram_sel,
  input  logic nwr,
  output logic nras,
  output logic ncas,
  output logic nwe,
  output logic mux_s,
  output logic nmux_oe,
  output logic busy
);

  localparam logic [CNT_W-1:0] R2M_LD = delay_load(RAS_TO_MUX);
  localparam logic [CNT_W-1:0] M2C_LD = delay_load(MUX_TO_CAS);
  localparam logic [CNT_W-1:0] PRE_LD = delay_load(PRECHARGE);

  state_e state_q, state_d;
  logic   nras_q, nras_d;
  logic   ncas_q, ncas_d;
  logic   nwe_q, nwe_d;
  logic   mux_s_q, mux_s_d;
  logic   nmux_oe_q, nmux_oe_d;
  logic   busy_q, busy_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             start;
  logic             to_prechg;

  dram_delay_cnt u_delay_cnt (
    .clk       (clk),
    .nrst      (nrst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    nras_d    = nras_q;
    ncas_d    = ncas_q;
    nwe_d     = nwe_q;
    mux_s_d   = mux_s_q;
    nmux_oe_d = nmux_oe_q;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    start     = 1'b0;
    to_prechg = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start = 1'b1;
      end
      ST_RAS: begin
        if (nmreq) begin
          to_prechg = 1'b1;
        end else if (cnt_zero) begin
          state_d  = ST_MUX;
          mux_s_d  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = M2C_LD;
        end
      end
      ST_MUX: begin
        if (nmreq) begin
          to_prechg = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_CAS;
          ncas_d  = 1'b0;
          nwe_d   = nwr;
        end
      end
      ST_CAS: begin
        if (nmreq) begin
          to_prechg = 1'b1;
        end else begin
          nwe_d = nwr;
        end
      end
      ST_RFSH: begin
        if (nmreq) begin
          to_prechg = 1'b1;
        end
      end
`ifdef DRAM_CBR_REFRESH_EN
      ST_CBR_CAS: begin
        if (nmreq) begin
          to_prechg = 1'b1;
        end else begin
          state_d = ST_CBR_RAS;
          nras_d  = 1'b0;
        end
      end
      ST_CBR_RAS: begin
        if (nmreq) begin
          to_prechg = 1'b1;
        end
      end
`endif
      ST_PRECHG: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          start   = 1'b1;
        end
      end
      default: begin
        to_prechg = 1'b1;
      end
    endcase

    if (to_prechg) begin
      state_d   = ST_PRECHG;
      nras_d    = 1'b1;
      ncas_d    = 1'b1;
      nwe_d     = 1'b1;
      mux_s_d   = 1'b0;
      nmux_oe_d = 1'b1;
      cnt_load  = 1'b1;
      cnt_val   = PRE_LD;
    end

    // Requests are never latched: only what is present on the deciding edge starts a cycle.
    if (start && !nmreq) begin
      if (!nrfsh) begin
`ifdef DRAM_CBR_REFRESH_EN
        state_d   = ST_CBR_CAS;
        nras_d    = 1'b1;
        ncas_d    = 1'b0;
        nmux_oe_d = 1'b1;
`else
        state_d   = ST_RFSH;
        nras_d    = 1'b0;
        ncas_d    = 1'b1;
        nmux_oe_d = 1'b0;
`endif
        nwe_d     = 1'b1;
        mux_s_d   = 1'b0;
      end else if (!nram_sel) begin
        state_d   = ST_RAS;
        nras_d    = 1'b0;
        ncas_d    = 1'b1;
        nwe_d     = 1'b1;
        mux_s_d   = 1'b0;
        nmux_oe_d = 1'b0;
        cnt_load  = 1'b1;
        cnt_val   = R2M_LD;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      nras_q    <= 1'b1;
      ncas_q    <= 1'b1;
      nwe_q     <= 1'b1;
      mux_s_q   <= 1'b0;
      nmux_oe_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nras_q    <= nras_d;
      ncas_q    <= ncas_d;
      nwe_q     <= nwe_d;
      mux_s_q   <= mux_s_d;
      nmux_oe_q <= nmux_oe_d;
      busy_q    <= busy_d;
    end
  end

  assign nras    = nras_q;
  assign ncas    = ncas_q;
  assign nwe     = nwe_q;
  assign mux_s   = mux_s_q;
  assign nmux_oe = nmux_oe_q;
  assign busy    = busy_q;

endmodule
